// File: rtl/pool_array_ctrl.sv
// Sequencing controller for the 16-lane 2x2/stride-2 pooling array.
// Replays one input tile to the lanes with row-end markers and writes lane results to sequential addresses.
module pool_array_ctrl #(
  parameter int POOL_NUM   = 16,
  parameter int DATA_WIDTH = 8,
  parameter int DIM_WIDTH  = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_i,
  input  logic [DIM_WIDTH-1:0]           width_i,
  input  logic [DIM_WIDTH-1:0]           height_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           cfg_err_o,
  output logic                           lane_err_o,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [POOL_NUM*DATA_WIDTH-1:0] in_data_i,
  output logic [POOL_NUM-1:0]            act_valid_o,
  output logic [POOL_NUM-1:0]            act_last_o,
  output logic [POOL_NUM*DATA_WIDTH-1:0] act_result_o,
  input  logic [POOL_NUM-1:0]            pool_valid_i,
  input  logic [POOL_NUM*DATA_WIDTH-1:0] pool_result_i,
  output logic                           wr_en_o,
  output logic [ADDR_WIDTH-1:0]          wr_addr_o,
  output logic [POOL_NUM*DATA_WIDTH-1:0] wr_data_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                 state, state_next;
  logic [DIM_WIDTH-1:0]   w_q, h_q, col, row;
  logic [ADDR_WIDTH-1:0]  out_cnt, out_target, cnt_next;
  logic [2*DIM_WIDTH-1:0] tile_outputs;
  logic                   cfg_legal, start_ok, accept, last_col, last_beat;
  logic                   collect, capture;

  assign cfg_legal = !width_i[0] && (width_i != '0) && !height_i[0] && (height_i != '0);
  assign start_ok  = (state == IDLE) && start_i && cfg_legal;
  assign accept    = in_valid_i && (state == RUN);
  assign last_col  = (col == w_q - DIM_WIDTH'(1));
  assign last_beat = last_col && (row == h_q - DIM_WIDTH'(1));
  assign collect   = (state == RUN) || (state == DRAIN);
  assign capture   = collect && pool_valid_i[0];
  // Completion compares against the count including this cycle's capture.
  assign cnt_next  = out_cnt + ADDR_WIDTH'(capture);
  assign tile_outputs = (2*DIM_WIDTH)'(width_i[DIM_WIDTH-1:1]) *
                        (2*DIM_WIDTH)'(height_i[DIM_WIDTH-1:1]);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = RUN;
      RUN:     if (accept && last_beat) state_next = (cnt_next == out_target) ? DONE : DRAIN;
      DRAIN:   if (cnt_next == out_target) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o = (state == RUN);
    busy_o     = (state != IDLE);
    done_o     = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q          <= '0;
      h_q          <= '0;
      col          <= '0;
      row          <= '0;
      out_cnt      <= '0;
      out_target   <= '0;
      cfg_err_o    <= 1'b0;
      lane_err_o   <= 1'b0;
      act_valid_o  <= '0;
      act_last_o   <= '0;
      act_result_o <= '0;
      wr_en_o      <= 1'b0;
      wr_addr_o    <= '0;
      wr_data_o    <= '0;
    end else begin
      cfg_err_o   <= (state == IDLE) && start_i && !cfg_legal;
      act_valid_o <= {POOL_NUM{accept}};
      act_last_o  <= {POOL_NUM{accept && last_col}};
      wr_en_o     <= capture;

      if (start_ok) begin
        w_q        <= width_i;
        h_q        <= height_i;
        out_target <= ADDR_WIDTH'(tile_outputs);
        col        <= '0;
        row        <= '0;
        out_cnt    <= '0;
        lane_err_o <= 1'b0;
      end else if (collect && (pool_valid_i != '0) && (pool_valid_i != '1)) begin
        lane_err_o <= 1'b1;
      end

      if (accept) begin
        act_result_o <= in_data_i;
        if (last_col) begin
          col <= '0;
          row <= row + DIM_WIDTH'(1);
        end else begin
          col <= col + DIM_WIDTH'(1);
        end
      end

      // Lane 0 decides the write even when the other lanes disagree.
      if (capture) begin
        wr_addr_o <= out_cnt;
        wr_data_o <= pool_result_i;
        out_cnt   <= out_cnt + ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_pool_array_ctrl.sv
// Directed self-checking bench for pool_array_ctrl.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_pool_array_ctrl;

  localparam int POOL_NUM   = 16;
  localparam int DATA_WIDTH = 8;
  localparam int DIM_WIDTH  = 8;
  localparam int ADDR_WIDTH = 12;
  localparam int BUS        = POOL_NUM*DATA_WIDTH;
  localparam logic [POOL_NUM-1:0] LANES_ALL  = '1;
  localparam logic [POOL_NUM-1:0] LANES_NONE = '0;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start_i;
  logic [DIM_WIDTH-1:0]  width_i, height_i;
  logic                  busy_o, done_o, cfg_err_o, lane_err_o;
  logic                  in_valid_i, in_ready_o;
  logic [BUS-1:0]        in_data_i;
  logic [POOL_NUM-1:0]   act_valid_o, act_last_o;
  logic [BUS-1:0]        act_result_o;
  logic [POOL_NUM-1:0]   pool_valid_i;
  logic [BUS-1:0]        pool_result_i;
  logic                  wr_en_o;
  logic [ADDR_WIDTH-1:0] wr_addr_o;
  logic [BUS-1:0]        wr_data_o;

  int checks = 0;
  int errors = 0;

  pool_array_ctrl #(
    .POOL_NUM(POOL_NUM), .DATA_WIDTH(DATA_WIDTH),
    .DIM_WIDTH(DIM_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .width_i(width_i), .height_i(height_i),
    .busy_o(busy_o), .done_o(done_o), .cfg_err_o(cfg_err_o), .lane_err_o(lane_err_o),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .act_valid_o(act_valid_o), .act_last_o(act_last_o), .act_result_o(act_result_o),
    .pool_valid_i(pool_valid_i), .pool_result_i(pool_result_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o)
  );

  always #5 clk = ~clk;

  function automatic logic [BUS-1:0] beatData(input int i);
    logic [BUS-1:0] salt;
    salt = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    return salt ^ {POOL_NUM{8'(i)}};
  endfunction

  function automatic logic [BUS-1:0] resultData(input int j);
    return ~beatData(j + 100);
  endfunction

  task automatic checkOutput(input string tag, input logic [BUS-1:0] actual, input logic [BUS-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of stream/lane inputs, then returns just after the edge that sampled them.
  task automatic applyStimulus(input logic valid, input logic [BUS-1:0] data,
                               input logic [POOL_NUM-1:0] pvalid, input logic [BUS-1:0] presult);
    in_valid_i    = valid;
    in_data_i     = data;
    pool_valid_i  = pvalid;
    pool_result_i = presult;
    @(posedge clk);
    #1;
    in_valid_i   = 1'b0;
    pool_valid_i = LANES_NONE;
    start_i      = 1'b0;
  endtask

  task automatic startTile(input logic [DIM_WIDTH-1:0] w, input logic [DIM_WIDTH-1:0] h);
    start_i  = 1'b1;
    width_i  = w;
    height_i = h;
    applyStimulus(1'b0, '0, LANES_NONE, '0);
  endtask

  task automatic checkResetState(input string pfx);
    checkOutput({pfx, "_in_ready"},   in_ready_o,   0);
    checkOutput({pfx, "_busy"},       busy_o,       0);
    checkOutput({pfx, "_done"},       done_o,       0);
    checkOutput({pfx, "_cfg_err"},    cfg_err_o,    0);
    checkOutput({pfx, "_lane_err"},   lane_err_o,   0);
    checkOutput({pfx, "_act_valid"},  act_valid_o,  0);
    checkOutput({pfx, "_act_last"},   act_last_o,   0);
    checkOutput({pfx, "_act_result"}, act_result_o, 0);
    checkOutput({pfx, "_wr_en"},      wr_en_o,      0);
    checkOutput({pfx, "_wr_addr"},    wr_addr_o,    0);
    checkOutput({pfx, "_wr_data"},    wr_data_o,    0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start_i = 1'b0; width_i = '0; height_i = '0;
    in_valid_i = 1'b0; in_data_i = '0; pool_valid_i = '0; pool_result_i = '0;
    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    rst = 1'b0;

    $display("[TB] basic 4x4");
    startTile(8'd4, 8'd4);
    checkOutput("basic_ready_after_start", in_ready_o, 1);
    checkOutput("basic_busy_after_start", busy_o, 1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, beatData(i), LANES_NONE, '0);
      checkOutput("basic_act_valid", act_valid_o, LANES_ALL);
      checkOutput("basic_act_last", act_last_o, (i % 4 == 3) ? LANES_ALL : LANES_NONE);
      checkOutput("basic_act_result", act_result_o, beatData(i));
    end
    checkOutput("basic_ready_drops", in_ready_o, 0);
    checkOutput("basic_busy_drain", busy_o, 1);
    for (int j = 0; j < 4; j++) begin
      applyStimulus(1'b0, '0, LANES_ALL, resultData(j));
      checkOutput("basic_act_valid_idle", act_valid_o, LANES_NONE);
      checkOutput("basic_wr_en", wr_en_o, 1);
      checkOutput("basic_wr_addr", wr_addr_o, j);
      checkOutput("basic_wr_data", wr_data_o, resultData(j));
      checkOutput("basic_done", done_o, (j == 3) ? 1 : 0);
    end
    applyStimulus(1'b0, '0, LANES_NONE, '0);
    checkOutput("basic_busy_after_done", busy_o, 0);
    checkOutput("basic_done_pulse", done_o, 0);
    checkOutput("basic_wr_en_off", wr_en_o, 0);

    $display("[TB] bubbles 2x2 with result on final beat");
    startTile(8'd2, 8'd2);
    begin
      int b;
      b = 0;
      for (int k = 0; k < 7; k++) begin
        logic v;
        v = (k % 2 == 0);
        applyStimulus(v, beatData(b), (v && b == 3) ? LANES_ALL : LANES_NONE, resultData(9));
        checkOutput("bubble_act_valid", act_valid_o, v ? LANES_ALL : LANES_NONE);
        checkOutput("bubble_act_last", act_last_o, (v && (b == 1 || b == 3)) ? LANES_ALL : LANES_NONE);
        if (v) b++;
      end
    end
    checkOutput("bubble_wr_en", wr_en_o, 1);
    checkOutput("bubble_wr_addr", wr_addr_o, 0);
    checkOutput("bubble_wr_data", wr_data_o, resultData(9));
    checkOutput("bubble_done_direct", done_o, 1);
    checkOutput("bubble_ready_low", in_ready_o, 0);
    applyStimulus(1'b0, '0, LANES_NONE, '0);
    checkOutput("bubble_busy_after", busy_o, 0);

    $display("[TB] illegal configurations");
    startTile(8'd3, 8'd4);
    checkOutput("illegal_w3_cfg_err", cfg_err_o, 1);
    checkOutput("illegal_w3_busy", busy_o, 0);
    checkOutput("illegal_w3_ready", in_ready_o, 0);
    applyStimulus(1'b0, '0, LANES_NONE, '0);
    checkOutput("illegal_w3_pulse_end", cfg_err_o, 0);
    startTile(8'd4, 8'd0);
    checkOutput("illegal_h0_cfg_err", cfg_err_o, 1);
    checkOutput("illegal_h0_busy", busy_o, 0);
    checkOutput("illegal_h0_ready", in_ready_o, 0);
    applyStimulus(1'b0, '0, LANES_NONE, '0);
    checkOutput("illegal_h0_pulse_end", cfg_err_o, 0);
    checkOutput("illegal_h0_still_idle", busy_o, 0);

    $display("[TB] lane mismatch 4x2");
    startTile(8'd4, 8'd2);
    for (int i = 0; i < 8; i++) begin
      logic [POOL_NUM-1:0] pv;
      pv = (i == 3) ? 16'h7FFF : ((i == 7) ? LANES_ALL : LANES_NONE);
      applyStimulus(1'b1, beatData(i), pv, resultData(20 + i));
      if (i == 3) begin
        checkOutput("mismatch_wr_en", wr_en_o, 1);
        checkOutput("mismatch_wr_addr", wr_addr_o, 0);
        checkOutput("mismatch_wr_data", wr_data_o, resultData(23));
        checkOutput("mismatch_lane_err", lane_err_o, 1);
      end
    end
    checkOutput("mismatch_final_addr", wr_addr_o, 1);
    checkOutput("mismatch_final_data", wr_data_o, resultData(27));
    checkOutput("mismatch_done", done_o, 1);
    checkOutput("mismatch_lane_err_sticky", lane_err_o, 1);
    applyStimulus(1'b0, '0, LANES_NONE, '0);
    checkOutput("mismatch_lane_err_idle", lane_err_o, 1);
    checkOutput("mismatch_busy_after", busy_o, 0);
    startTile(8'd2, 8'd2);
    checkOutput("mismatch_cleared_by_start", lane_err_o, 0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, beatData(i), (i == 3) ? LANES_ALL : LANES_NONE, resultData(30));
    checkOutput("mismatch_next_done", done_o, 1);
    checkOutput("mismatch_next_addr", wr_addr_o, 0);
    applyStimulus(1'b0, '0, LANES_NONE, '0);

    $display("[TB] start while busy");
    startTile(8'd4, 8'd2);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        start_i  = 1'b1;
        width_i  = 8'd2;
        height_i = 8'd2;
      end
      applyStimulus(1'b1, beatData(i), LANES_NONE, '0);
      checkOutput("busystart_act_last", act_last_o, (i % 4 == 3) ? LANES_ALL : LANES_NONE);
      checkOutput("busystart_ready", in_ready_o, (i == 7) ? 0 : 1);
      checkOutput("busystart_cfg_err", cfg_err_o, 0);
    end
    checkOutput("busystart_drain_busy", busy_o, 1);
    for (int j = 0; j < 2; j++) begin
      applyStimulus(1'b0, '0, LANES_ALL, resultData(50 + j));
      checkOutput("busystart_wr_addr", wr_addr_o, j);
      checkOutput("busystart_done", done_o, (j == 1) ? 1 : 0);
    end
    applyStimulus(1'b0, '0, LANES_NONE, '0);
    checkOutput("busystart_busy_after", busy_o, 0);

    $display("[TB] reset mid-run");
    startTile(8'd8, 8'd8);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, beatData(i), (i == 2) ? 16'h0001 : LANES_NONE, resultData(40));
    checkOutput("midreset_lane_err_before", lane_err_o, 1);
    rst = 1'b1;
    applyStimulus(1'b1, beatData(5), LANES_ALL, resultData(41));
    checkResetState("midreset");
    rst = 1'b0;
    startTile(8'd2, 8'd2);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, beatData(i), (i == 3) ? LANES_ALL : LANES_NONE, resultData(42));
    checkOutput("midreset_fresh_wr_en", wr_en_o, 1);
    checkOutput("midreset_fresh_addr", wr_addr_o, 0);
    checkOutput("midreset_fresh_data", wr_data_o, resultData(42));
    checkOutput("midreset_fresh_done", done_o, 1);
    applyStimulus(1'b0, '0, LANES_NONE, '0);
    checkOutput("midreset_fresh_idle", busy_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
